serterm_rx_decoder: RTL and testbench



---
 rtl/serterm_pkg.sv | 30 +++
 rtl/serterm_fifo.sv | 76 +++++++
 rtl/serterm_rx_decoder.sv | 129 ++++++++++++
 tb/tb_serterm_rx_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serterm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serterm_pkg
//  Purpose  : Shared types and character constants for the serial-terminal
//             receive path (decoder state encoding, control characters,
//             printable-range bounds, byte classification helper).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serterm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_FF  = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // True for bytes the terminal draws: printable ASCII plus CR and LF.
  function automatic logic is_drawable(input logic [7:0] b);
    return ((b >= PRINT_LO) && (b <= PRINT_HI)) || (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serterm_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : serterm_fifo
//  Purpose  : Synchronous byte FIFO with occupancy count. Full/empty are
//             derived from the registered count; pointers wrap naturally.
//  Ports    : i_clk, i_rst_n      - clock, synchronous active-low reset
//             wr_en_i, wr_data_i  - write request and byte (ignored when full)
//             rd_en_i, rd_data_o  - pop request (ignored when empty), head byte
//             full_o, empty_o     - status from the registered count
//             level_o             - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module serterm_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_en_i,
  output logic [7:0]               rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          w_wr, w_rd;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Requests are re-qualified here so the FIFO is safe on its own.
  assign w_wr = wr_en_i && !full_o;
  assign w_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_wr, w_rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/serterm_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : serterm_rx_decoder
//  Purpose  : Buffers bytes from the UART receiver and turns each one into a
//             single putchar / clearhome pulse for the terminal control block,
//             issuing the next command only once control reports idle.
//  Ports    : i_clk, i_rst_n           - clock, synchronous active-low reset
//             s_axis_tdata/tvalid/tready - byte input stream
//             i_busy                    - control is executing a command
//             o_putchar, o_char         - draw-character pulse and character
//             o_clearhome               - clear-screen/home pulse
//             o_level                   - FIFO occupancy
//             m_axis_tdata/tvalid/tready- echo stream (SERTERM_ECHO_EN only)
//  Options  : `define SERTERM_ECHO_EN to add the echo output stream.
//  Revision : 1.0 - initial release
// ============================================================================
module serterm_rx_decoder
  import serterm_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CLEAR_CHAR = 8'h0C
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          i_busy,
  output logic                          o_putchar,
  output logic                          o_clearhome,
  output logic [7:0]                    o_char,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
`ifdef SERTERM_ECHO_EN
  ,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
`endif
);

  state_e     state_q;
  logic       putchar_q;
  logic       clearhome_q;
  logic [7:0] char_q;

  logic       w_full, w_empty, w_wr, w_pop, w_echo_block;
  logic [7:0] w_head;

  // tready comes from the registered count, so a full FIFO refuses a write
  // even on an edge that also pops.
  assign s_axis_tready = i_rst_n && !w_full;
  assign w_wr          = s_axis_tvalid && s_axis_tready;

`ifdef SERTERM_ECHO_EN
  logic       echo_valid_q;
  logic [7:0] echo_data_q;
  assign w_echo_block  = echo_valid_q;
  assign m_axis_tdata  = echo_data_q;
  assign m_axis_tvalid = echo_valid_q;
`else
  assign w_echo_block  = 1'b0;
`endif

  assign w_pop = (state_q == IDLE) && !w_empty && !i_busy && !w_echo_block;

  serterm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .wr_en_i   (w_wr),
    .wr_data_i (s_axis_tdata),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (o_level)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      putchar_q   <= 1'b0;
      clearhome_q <= 1'b0;
      char_q      <= 8'h00;
`ifdef SERTERM_ECHO_EN
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
`endif
    end else begin
      putchar_q   <= 1'b0;
      clearhome_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_pop) begin
            if (is_drawable(w_head)) begin
              putchar_q <= 1'b1;
              char_q    <= w_head;
              state_q   <= HOLD;
            end else if (w_head == CLEAR_CHAR) begin
              clearhome_q <= 1'b1;
              state_q     <= HOLD;
            end
            // Anything else is consumed silently and IDLE may pop again.
          end
        end
        // One cycle of slack so control can raise i_busy before WAIT samples it.
        HOLD:    state_q <= WAIT;
        WAIT:    if (!i_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef SERTERM_ECHO_EN
      // Pops only happen with no echo pending, so load and clear never collide.
      if (w_pop) begin
        echo_valid_q <= 1'b1;
        echo_data_q  <= w_head;
      end else if (echo_valid_q && m_axis_tready) begin
        echo_valid_q <= 1'b0;
      end
`endif
    end
  end

  assign o_putchar   = putchar_q;
  assign o_clearhome = clearhome_q;
  assign o_char      = char_q;

endmodule
`default_nettype wire

// File: tb/tb_serterm_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serterm_rx_decoder
//  Purpose  : Self-checking bench for serterm_rx_decoder: directed timing
//             cases plus randomized byte streams scored against a
//             command-queue reference model.
//  Options  : `define SERTERM_ECHO_EN to exercise the echo stream as well.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serterm_rx_decoder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tready;
  logic       busy = 1'b0;
  logic       o_putchar, o_clearhome;
  logic [7:0] o_char;
  logic [4:0] o_level;
`ifdef SERTERM_ECHO_EN
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
`endif

  always #5 clk = ~clk;

  serterm_rx_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CLEAR_CHAR (8'h0C)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .i_busy        (busy),
    .o_putchar     (o_putchar),
    .o_clearhome   (o_clearhome),
    .o_char        (o_char),
    .o_level       (o_level)
`ifdef SERTERM_ECHO_EN
    ,
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the ordered list of commands the terminal should see.
  // Entry {0,ch} = putchar ch, 9'h100 = clearhome. Dropped bytes never enter.
  logic [8:0] exp_q[$];
  logic [7:0] echo_q[$];

  function automatic logic [8:0] expect_cmd(input logic [7:0] b);
    if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0D || b == 8'h0A) return {1'b0, b};
    if (b == 8'h0C) return 9'h100;
    return 9'h1FF;
  endfunction

  // Pulse monitor and scoreboard.
  int         cyc = 0;
  int         last_pulse = -100;
  int         pulses = 0;
  logic       prev_busy = 1'b0;
  logic [8:0] obs_cmd;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_putchar || o_clearhome) begin
        chk_eq("one_hot", {31'd0, o_putchar & o_clearhome}, 0);
        obs_cmd = o_clearhome ? 9'h100 : {1'b0, o_char};
        if (exp_q.size() == 0) chk_eq("unexpected_pulse", obs_cmd, 9'h1FF);
        else chk_eq("cmd", obs_cmd, exp_q.pop_front());
        if (last_pulse >= 0) chk_eq("spacing", {31'd0, (cyc - last_pulse) >= 3}, 1);
        // busy as seen on the pop edge that produced this pulse
        chk_eq("busy_at_pop", {31'd0, prev_busy}, 0);
        last_pulse = cyc;
        pulses++;
      end
`ifdef SERTERM_ECHO_EN
      if (m_tvalid && m_tready) begin
        if (echo_q.size() == 0) chk_eq("echo_unexpected", {24'd0, m_tdata}, 32'h1FF);
        else chk_eq("echo_data", {24'd0, m_tdata}, {24'd0, echo_q.pop_front()});
      end
`endif
    end else begin
      last_pulse = -100;
    end
    prev_busy = busy;
  end

  // Behavioural 'control' block: busy for busy_len cycles after each pulse,
  // or continuously while busy_hold is set.
  int   busy_len = 0;
  int   bcnt = 0;
  logic busy_hold = 1'b0;

  always @(posedge clk) begin
    #2;
    if (!rst_n) bcnt = 0;
    else if ((o_putchar || o_clearhome) && busy_len > 0) bcnt = busy_len;
    if (busy_hold) busy = 1'b1;
    else if (bcnt > 0) begin
      busy = 1'b1;
      bcnt--;
    end else busy = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic [8:0] e;
    n = 0;
    tvalid = 1'b1;
    tdata  = b;
    while (!tready && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk_eq("tready_timeout", {31'd0, tready}, 1);
    e = expect_cmd(b);
    if (e != 9'h1FF) exp_q.push_back(e);
    echo_q.push_back(b);
    step();
    tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_level != 0) && n < 3000) begin
      step();
      n++;
    end
    repeat (6) step();
    chk_eq("drain_queue", exp_q.size(), 0);
    chk_eq("drain_level", {27'd0, o_level}, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 8'h0C;
      1:       return 8'h0D;
      2:       return 8'h0A;
      3:       return 8'($urandom_range(0, 255));
      default: return 8'(8'h20 + $urandom_range(0, 94));
    endcase
  endfunction

  initial begin
    int p;
    // Reset values
    rst_n = 1'b0;
    repeat (3) step();
    chk_eq("rst_putchar",   {31'd0, o_putchar}, 0);
    chk_eq("rst_clearhome", {31'd0, o_clearhome}, 0);
    chk_eq("rst_char",      {24'd0, o_char}, 0);
    chk_eq("rst_level",     {27'd0, o_level}, 0);
    chk_eq("rst_tready",    {31'd0, tready}, 0);
    rst_n = 1'b1;
    step();
    chk_eq("tready_after_rst", {31'd0, tready}, 1);

    // Single putchar: pulse lives between edges E+1 and E+2.
    send_byte(8'h41);
    chk_eq("A_edgeE_pulse", {31'd0, o_putchar}, 0);
    step();
    chk_eq("A_pulse",     {31'd0, o_putchar}, 1);
    chk_eq("A_char",      {24'd0, o_char}, 32'h41);
    chk_eq("A_clearhome", {31'd0, o_clearhome}, 0);
    step();
    chk_eq("A_pulse_end", {31'd0, o_putchar}, 0);
    chk_eq("A_char_held", {24'd0, o_char}, 32'h41);
    drain();

    // Clear character, then a discarded bell.
    send_byte(8'h0C);
    drain();
    p = pulses;
    send_byte(8'h07);
    drain();
    chk_eq("bell_no_pulse", pulses, p);

    // Backpressure: fill while control is busy.
    busy_hold = 1'b1;
    repeat (2) step();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h30 + i));
    chk_eq("full_level",  {27'd0, o_level}, DEPTH);
    chk_eq("full_tready", {31'd0, tready}, 0);
    tvalid = 1'b1;
    tdata  = 8'h50;
    repeat (3) step();
    chk_eq("full_no_drop", {27'd0, o_level}, DEPTH);
    busy_hold = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i));
    drain();

    // Long busy after every command.
    busy_len = 10;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + $urandom_range(0, 94)));
    drain();

    // Randomized traffic and control latency.
    for (int i = 0; i < 60; i++) begin
      busy_len = $urandom_range(0, 4);
      repeat ($urandom_range(0, 3)) step();
      send_byte(rand_byte());
    end
    drain();
    busy_len = 0;

`ifdef SERTERM_ECHO_EN
    // Echo pending stalls the next pop.
    m_tready = 1'b0;
    send_byte(8'h42);
    send_byte(8'h43);
    repeat (8) step();
    chk_eq("echo_stall_level", {27'd0, o_level}, 1);
    chk_eq("echo_valid",       {31'd0, m_tvalid}, 1);
    chk_eq("echo_first",       {24'd0, m_tdata}, 32'h42);
    m_tready = 1'b1;
    drain();
`endif

    // Reset mid-burst while sitting in WAIT.
    busy_len = 50;
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    repeat (6) step();
    rst_n = 1'b0;
    exp_q.delete();
    echo_q.delete();
    step();
    chk_eq("mid_rst_putchar",   {31'd0, o_putchar}, 0);
    chk_eq("mid_rst_clearhome", {31'd0, o_clearhome}, 0);
    chk_eq("mid_rst_char",      {24'd0, o_char}, 0);
    chk_eq("mid_rst_level",     {27'd0, o_level}, 0);
    chk_eq("mid_rst_tready",    {31'd0, tready}, 0);
`ifdef SERTERM_ECHO_EN
    chk_eq("mid_rst_echo",      {31'd0, m_tvalid}, 0);
`endif
    busy_len = 0;
    rst_n = 1'b1;
    step();
    chk_eq("post_rst_tready", {31'd0, tready}, 1);
    p = pulses;
    repeat (20) step();
    chk_eq("no_stale_pulse", pulses, p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
